// File: rtl/prog_loader.sv
// Streaming program-RAM loader: accepts bytes over valid/ready and writes them to
// consecutive addresses from a latched base, with a running checksum and done pulse.
module prog_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_count,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  aborted_q, aborted_d;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      byte_q      <= '0;
      checksum_q  <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      checksum_q  <= checksum_d;
      aborted_q   <= aborted_d;
    end
  end

  // addr_q/byte_q are captured at the handshake so the RAM bus holds its last
  // write while ptr advances to the next address.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    checksum_d  = checksum_q;
    aborted_d   = aborted_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d       = base;
          remaining_d = (len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, len};
          checksum_d  = '0;
          aborted_d   = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (in_valid) begin
          byte_d  = in_data;
          addr_d  = ptr_q;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The strobe is already on the bus, so bookkeeping completes even on abort.
        ptr_d       = ptr_q + ADDR_WIDTH'(1);
        checksum_d  = checksum_q + byte_q;
        remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign ram_we    = (state_q == WRITE);
  assign busy      = (state_q == LOAD) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign ram_addr  = addr_q;
  assign ram_wdata = byte_q;
  assign aborted   = aborted_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a scoreboard queue of expected RAM writes
// is filled as bytes are offered and drained by a monitor watching ram_we.
module tb_prog_loader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_count;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          abort;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int first_hs_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;
  int we_count = 0;
  int d0, w0;

  logic [AW+DW-1:0] exp_q[$];

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_count(reset_count), .start(start), .base(base), .len(len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
    .done(done), .aborted(aborted), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every observed write must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    logic [AW+DW-1:0] e;
    if (done) done_count <= done_count + 1;
    if (ram_we === 1'b1) begin
      we_count <= we_count + 1;
      if (exp_q.size() == 0) begin
        check_output("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_output("write_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
        check_output("write_data", 32'(ram_wdata), 32'(e[DW-1:0]));
      end
    end
  end

  task automatic start_load(input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    check_output("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input logic [AW-1:0] a);
    int n = 0;
    exp_q.push_back({a, d});
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("timeout_in_ready", 32'(in_ready), 32'd1);
    last_hs_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(done), 32'd1);
    done_cyc = cyc;
  endtask

  initial begin
    reset_count = 1'b1;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base = '0; len = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_ram_we", 32'(ram_we), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_checksum", 32'(checksum), 32'd0);
    reset_count = 1'b0;
    @(negedge clk);

    // Reset asserted mid-WRITE drops everything without waiting for a clock.
    start_load(4'd3, 4'd2);
    send_byte(8'hAA, 4'd3);
    check_output("t1_we_before_reset", 32'(ram_we), 32'd1);
    #2 reset_count = 1'b1;
    #1;
    check_output("t1_ram_we", 32'(ram_we), 32'd0);
    check_output("t1_busy", 32'(busy), 32'd0);
    check_output("t1_in_ready", 32'(in_ready), 32'd0);
    check_output("t1_done", 32'(done), 32'd0);
    check_output("t1_aborted", 32'(aborted), 32'd0);
    check_output("t1_ram_addr", 32'(ram_addr), 32'd0);
    check_output("t1_ram_wdata", 32'(ram_wdata), 32'd0);
    check_output("t1_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    reset_count = 1'b0;
    @(negedge clk);

    // Back-to-back three-byte load.
    d0 = done_count;
    start_load(4'd0, 4'd3);
    send_byte(8'h41, 4'd0);
    first_hs_cyc = last_hs_cyc;
    send_byte(8'h82, 4'd1);
    send_byte(8'h05, 4'd2);
    wait_done("t2_done");
    check_output("t2_latency", 32'(done_cyc - first_hs_cyc), 32'd6);
    check_output("t2_checksum", 32'(checksum), 32'hC8);
    repeat (3) @(negedge clk);
    check_output("t2_done_once", 32'(done_count - d0), 32'd1);
    check_output("t2_idle_busy", 32'(busy), 32'd0);

    // Full-depth load wrapping past the top address.
    d0 = done_count;
    start_load(4'd14, 4'd0);
    for (int i = 0; i < 16; i++) send_byte(DW'(i + 1), AW'(14 + i));
    wait_done("t3_done");
    check_output("t3_checksum", 32'(checksum), 32'h88);
    repeat (3) @(negedge clk);
    check_output("t3_done_once", 32'(done_count - d0), 32'd1);

    // Gaps on in_valid keep the loader waiting in LOAD.
    w0 = we_count;
    start_load(4'd5, 4'd2);
    send_byte(8'h11, 4'd5);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_output("t4_ready_in_gap", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    send_byte(8'h22, 4'd6);
    wait_done("t4_done");
    repeat (2) @(negedge clk);
    check_output("t4_write_count", 32'(we_count - w0), 32'd2);
    check_output("t4_checksum", 32'(checksum), 32'h33);

    // Abort after two writes, coincident with in_valid so abort must win.
    d0 = done_count;
    w0 = we_count;
    start_load(4'd0, 4'd4);
    send_byte(8'h10, 4'd0);
    send_byte(8'h20, 4'd1);
    @(negedge clk);
    check_output("t5_in_load", 32'(in_ready), 32'd1);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check_output("t5_busy", 32'(busy), 32'd0);
    check_output("t5_aborted", 32'(aborted), 32'd1);
    repeat (5) @(negedge clk);
    check_output("t5_no_done", 32'(done_count - d0), 32'd0);
    check_output("t5_write_count", 32'(we_count - w0), 32'd2);
    check_output("t5_checksum", 32'(checksum), 32'h30);

    // in_valid in IDLE and start during LOAD are both ignored.
    d0 = done_count;
    w0 = we_count;
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) begin
      @(negedge clk);
      check_output("t6_idle_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check_output("t6_idle_no_write", 32'(we_count - w0), 32'd0);
    start_load(4'd8, 4'd2);
    check_output("t6_aborted_cleared", 32'(aborted), 32'd0);
    check_output("t6_checksum_cleared", 32'(checksum), 32'd0);
    start = 1'b1; base = 4'd3; len = 4'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h5A, 4'd8);
    send_byte(8'hA5, 4'd9);
    wait_done("t6_done");
    check_output("t6_checksum", 32'(checksum), 32'hFF);
    repeat (3) @(negedge clk);
    check_output("t6_done_once", 32'(done_count - d0), 32'd1);
    check_output("t6_write_count", 32'(we_count - w0), 32'd2);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
